// File: rtl/ctrl_stack_pkg.sv
// Shared types for the call/return/data stack: FSM states, flag width, op priority.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package ctrl_stack_pkg;

  localparam int FLAGW = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INT_SV  = 2'd1,
    RETI_PC = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_RETI = 3'd1,
    OP_CALL = 3'd2,
    OP_RET  = 3'd3,
    OP_PUSH = 3'd4,
    OP_POP  = 3'd5,
    OP_INT  = 3'd6
  } op_t;

  // Single winner per cycle: reti > call > ret > push > pop > pending interrupt.
  function automatic op_t pick_op(input logic reti, input logic call, input logic ret,
                                  input logic push, input logic pop, input logic irq);
    op_t op;
    if (reti)      op = OP_RETI;
    else if (call) op = OP_CALL;
    else if (ret)  op = OP_RET;
    else if (push) op = OP_PUSH;
    else if (pop)  op = OP_POP;
    else if (irq)  op = OP_INT;
    else           op = OP_NONE;
    return op;
  endfunction

endpackage

// File: rtl/lifo_mem.sv
// Stack storage: DEPTH x W array, one synchronous write port, one combinational read port.
// Latency: write lands at the clock edge; read data follows raddr in the same cycle.
// Backpressure: none; the caller guards writes against a full stack.
module lifo_mem #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Contents are deliberately not reset; only the stack pointer defines validity.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ctrl_stack.sv
// Call/return + data stack with 2-cycle interrupt entry/exit saving PC and flags.
// Latency: every op sampled at edge k is visible after edge k; interrupt vector 3 edges after eint rise.
// Backpressure: busy stalls the core during interrupt sequences; full/empty errors set sticky ovf/unf.
// Interrupt support is compiled in when CTRL_STACK_INT_EN is defined.
module ctrl_stack
  import ctrl_stack_pkg::*;
#(
  parameter int           W       = 8,
  parameter int           DEPTH   = 16,
  parameter logic [W-1:0] INT_VEC = 8'h10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   call,
  input  logic                   ret,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   reti,
  input  logic                   eint,
  input  logic                   clr_err,
  input  logic [W-1:0]           pc_in,
  input  logic [W-1:0]           data_in,
  input  logic [FLAGW-1:0]       flags_in,
  output logic [W-1:0]           data_out,
  output logic [W-1:0]           ret_pc,
  output logic                   pc_load,
  output logic [FLAGW-1:0]       flags_out,
  output logic                   flags_load,
  output logic [W-1:0]           lnk,
  output logic                   busy,
  output logic                   full,
  output logic                   empty,
  output logic                   ovf,
  output logic                   unf,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

`ifdef CTRL_STACK_INT_EN
  localparam logic INT_EN = 1'b1;
`else
  localparam logic INT_EN = 1'b0;
`endif

  state_t          state, state_n;
  op_t             op;
  logic [LW-1:0]   level_n;
  logic [W-1:0]    data_out_n, ret_pc_n, lnk_n;
  logic [FLAGW-1:0] flags_out_n;
  logic            pc_load_n, flags_load_n, busy_n;
  logic            ovf_set, unf_set;
  logic            pending, pending_n, pend_clr;
  logic            in_isr, in_isr_n;
  logic            eint_q, eint_rise, irq_ok;
  logic            mem_we;
  logic [W-1:0]    mem_wdata, mem_rdata, flags_ext;
  logic [AW-1:0]   waddr, raddr;
  logic            is_full, is_empty;

  assign is_full   = (level == LW'(DEPTH));
  assign is_empty  = (level == '0);
  assign waddr     = level[AW-1:0];
  assign raddr     = level[AW-1:0] - AW'(1);
  assign eint_rise = eint & ~eint_q;
  // Entry needs two free slots: one for PC, one for flags.
  assign irq_ok    = INT_EN & pending & ~in_isr & (level <= LW'(DEPTH - 2));

  lifo_mem #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (waddr),
    .wdata (mem_wdata),
    .raddr (raddr),
    .rdata (mem_rdata)
  );

  // Flags are stored zero-extended to the stack word width.
  always_comb begin
    flags_ext             = '0;
    flags_ext[FLAGW-1:0]  = flags_in;
  end

  // Next-state and datapath decode: one winning op per idle cycle, fixed two-step sequences otherwise.
  always_comb begin
    state_n      = state;
    op           = OP_NONE;
    level_n      = level;
    data_out_n   = data_out;
    ret_pc_n     = ret_pc;
    lnk_n        = lnk;
    flags_out_n  = flags_out;
    pc_load_n    = 1'b0;
    flags_load_n = 1'b0;
    busy_n       = 1'b0;
    ovf_set      = 1'b0;
    unf_set      = 1'b0;
    pend_clr     = 1'b0;
    in_isr_n     = in_isr;
    mem_we       = 1'b0;
    mem_wdata    = '0;
    case (state)
      IDLE: begin
        // busy also covers the cycle after a sequence, while the core takes the new PC.
        if (!busy) begin
          op = pick_op(reti & INT_EN, call, ret, push, pop, irq_ok);
          case (op)
            OP_RETI: begin
              if (level >= LW'(2)) begin
                flags_out_n  = mem_rdata[FLAGW-1:0];
                flags_load_n = 1'b1;
                level_n      = level - LW'(1);
                busy_n       = 1'b1;
                state_n      = RETI_PC;
              end else begin
                unf_set = 1'b1;
              end
            end
            OP_CALL: begin
              if (is_full) begin
                ovf_set = 1'b1;
              end else begin
                mem_we    = 1'b1;
                mem_wdata = pc_in + W'(1);
                lnk_n     = pc_in + W'(1);
                level_n   = level + LW'(1);
              end
            end
            OP_RET: begin
              if (is_empty) begin
                unf_set = 1'b1;
              end else begin
                ret_pc_n  = mem_rdata;
                pc_load_n = 1'b1;
                level_n   = level - LW'(1);
              end
            end
            OP_PUSH: begin
              if (is_full) begin
                ovf_set = 1'b1;
              end else begin
                mem_we    = 1'b1;
                mem_wdata = data_in;
                level_n   = level + LW'(1);
              end
            end
            OP_POP: begin
              if (is_empty) begin
                unf_set = 1'b1;
              end else begin
                data_out_n = mem_rdata;
                level_n    = level - LW'(1);
              end
            end
            OP_INT: begin
              mem_we    = 1'b1;
              mem_wdata = pc_in;
              level_n   = level + LW'(1);
              busy_n    = 1'b1;
              state_n   = INT_SV;
            end
            default: begin
            end
          endcase
        end
      end
      INT_SV: begin
        mem_we    = 1'b1;
        mem_wdata = flags_ext;
        level_n   = level + LW'(1);
        ret_pc_n  = INT_VEC;
        pc_load_n = 1'b1;
        in_isr_n  = 1'b1;
        pend_clr  = 1'b1;
        busy_n    = 1'b1;
        state_n   = IDLE;
      end
      RETI_PC: begin
        ret_pc_n  = mem_rdata;
        pc_load_n = 1'b1;
        level_n   = level - LW'(1);
        in_isr_n  = 1'b0;
        busy_n    = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // A new edge arriving as the old request is consumed is kept.
    pending_n = INT_EN & (eint_rise | (pending & ~pend_clr));
  end

  // State and output registers; reset aborts any sequence but leaves memory alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      level      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      ovf        <= 1'b0;
      unf        <= 1'b0;
      data_out   <= '0;
      ret_pc     <= '0;
      pc_load    <= 1'b0;
      flags_out  <= '0;
      flags_load <= 1'b0;
      lnk        <= '0;
      busy       <= 1'b0;
      pending    <= 1'b0;
      in_isr     <= 1'b0;
      eint_q     <= 1'b0;
    end else begin
      state      <= state_n;
      level      <= level_n;
      full       <= (level_n == LW'(DEPTH));
      empty      <= (level_n == '0);
      ovf        <= (ovf & ~clr_err) | ovf_set;
      unf        <= (unf & ~clr_err) | unf_set;
      data_out   <= data_out_n;
      ret_pc     <= ret_pc_n;
      pc_load    <= pc_load_n;
      flags_out  <= INT_EN ? flags_out_n : '0;
      flags_load <= INT_EN & flags_load_n;
      lnk        <= lnk_n;
      busy       <= INT_EN & busy_n;
      pending    <= pending_n;
      in_isr     <= INT_EN & in_isr_n;
      eint_q     <= eint;
    end
  end

endmodule

// File: tb/tb_ctrl_stack.sv
// Directed bench for ctrl_stack (W=8, DEPTH=4, INT_VEC=8'h10): table of single-cycle ops,
// then hand sequences for interrupt entry/exit, pending during ISR, and mid-sequence reset.
// Interrupt sequences apply when CTRL_STACK_INT_EN is defined; otherwise interrupts must be inert.
module tb_ctrl_stack;

  logic       clk = 1'b0;
  logic       rst;
  logic       call, ret, push, pop, reti, eint, clr_err;
  logic [7:0] pc_in, data_in;
  logic [3:0] flags_in;
  logic [7:0] data_out, ret_pc, lnk;
  logic       pc_load, flags_load, busy, full, empty, ovf, unf;
  logic [3:0] flags_out;
  logic [2:0] level;

  int n_vec = 0;
  int n_bad = 0;

  ctrl_stack #(.W(8), .DEPTH(4), .INT_VEC(8'h10)) dut (
    .clk(clk), .rst(rst), .call(call), .ret(ret), .push(push), .pop(pop),
    .reti(reti), .eint(eint), .clr_err(clr_err), .pc_in(pc_in), .data_in(data_in),
    .flags_in(flags_in), .data_out(data_out), .ret_pc(ret_pc), .pc_load(pc_load),
    .flags_out(flags_out), .flags_load(flags_load), .lnk(lnk), .busy(busy),
    .full(full), .empty(empty), .ovf(ovf), .unf(unf), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] ops;   // {call, ret, push, pop, clr_err}
    logic [7:0] pc;
    logic [7:0] din;
    logic [7:0] e_dout;
    logic [7:0] e_rpc;
    logic       e_pl;
    logic [7:0] e_lnk;
    logic [2:0] e_lvl;
    logic [3:0] e_st;  // {full, empty, ovf, unf}
  } vec_t;

  vec_t vt[26];

  function automatic vec_t v(input logic [4:0] ops, input logic [7:0] pc, input logic [7:0] din,
                             input logic [7:0] dout, input logic [7:0] rpc, input logic pl,
                             input logic [7:0] lk, input logic [2:0] lvl, input logic [3:0] st);
    vec_t r;
    r.ops = ops; r.pc = pc; r.din = din; r.e_dout = dout; r.e_rpc = rpc;
    r.e_pl = pl; r.e_lnk = lk; r.e_lvl = lvl; r.e_st = st;
    return r;
  endfunction

  function automatic logic [37:0] outs();
    return {data_out, ret_pc, pc_load, lnk, level, full, empty, ovf, unf, busy, flags_load, flags_out};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [37:0] act, input logic [37:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    call = 0; ret = 0; push = 0; pop = 0; reti = 0; eint = 0; clr_err = 0;
    pc_in = 8'h00; data_in = 8'h00; flags_in = 4'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  localparam logic [37:0] RST_OUTS = {8'h00, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};

  initial begin
    // Expected values hand-derived for DEPTH=4.
    vt[0]  = v(5'b00100, 8'h00, 8'h11, 8'h00, 8'h00, 0, 8'h00, 3'd1, 4'b0000);
    vt[1]  = v(5'b00100, 8'h00, 8'h22, 8'h00, 8'h00, 0, 8'h00, 3'd2, 4'b0000);
    vt[2]  = v(5'b00010, 8'h00, 8'h00, 8'h22, 8'h00, 0, 8'h00, 3'd1, 4'b0000);
    vt[3]  = v(5'b00010, 8'h00, 8'h00, 8'h11, 8'h00, 0, 8'h00, 3'd0, 4'b0100);
    vt[4]  = v(5'b10000, 8'hA1, 8'h00, 8'h11, 8'h00, 0, 8'hA2, 3'd1, 4'b0000);
    vt[5]  = v(5'b01000, 8'h00, 8'h00, 8'h11, 8'hA2, 1, 8'hA2, 3'd0, 4'b0100);
    vt[6]  = v(5'b00000, 8'h00, 8'h00, 8'h11, 8'hA2, 0, 8'hA2, 3'd0, 4'b0100);
    vt[7]  = v(5'b00100, 8'h00, 8'h01, 8'h11, 8'hA2, 0, 8'hA2, 3'd1, 4'b0000);
    vt[8]  = v(5'b00100, 8'h00, 8'h02, 8'h11, 8'hA2, 0, 8'hA2, 3'd2, 4'b0000);
    vt[9]  = v(5'b00100, 8'h00, 8'h03, 8'h11, 8'hA2, 0, 8'hA2, 3'd3, 4'b0000);
    vt[10] = v(5'b00100, 8'h00, 8'h04, 8'h11, 8'hA2, 0, 8'hA2, 3'd4, 4'b1000);
    vt[11] = v(5'b00100, 8'h00, 8'h05, 8'h11, 8'hA2, 0, 8'hA2, 3'd4, 4'b1010);
    vt[12] = v(5'b10000, 8'h50, 8'h00, 8'h11, 8'hA2, 0, 8'hA2, 3'd4, 4'b1010);
    vt[13] = v(5'b00010, 8'h00, 8'h00, 8'h04, 8'hA2, 0, 8'hA2, 3'd3, 4'b0010);
    vt[14] = v(5'b00001, 8'h00, 8'h00, 8'h04, 8'hA2, 0, 8'hA2, 3'd3, 4'b0000);
    vt[15] = v(5'b00010, 8'h00, 8'h00, 8'h03, 8'hA2, 0, 8'hA2, 3'd2, 4'b0000);
    vt[16] = v(5'b00010, 8'h00, 8'h00, 8'h02, 8'hA2, 0, 8'hA2, 3'd1, 4'b0000);
    vt[17] = v(5'b01000, 8'h00, 8'h00, 8'h02, 8'h01, 1, 8'hA2, 3'd0, 4'b0100);
    vt[18] = v(5'b00010, 8'h00, 8'h00, 8'h02, 8'h01, 0, 8'hA2, 3'd0, 4'b0101);
    vt[19] = v(5'b01000, 8'h00, 8'h00, 8'h02, 8'h01, 0, 8'hA2, 3'd0, 4'b0101);
    vt[20] = v(5'b00011, 8'h00, 8'h00, 8'h02, 8'h01, 0, 8'hA2, 3'd0, 4'b0101);
    vt[21] = v(5'b00001, 8'h00, 8'h00, 8'h02, 8'h01, 0, 8'hA2, 3'd0, 4'b0100);
    vt[22] = v(5'b10100, 8'h30, 8'h99, 8'h02, 8'h01, 0, 8'h31, 3'd1, 4'b0000);
    vt[23] = v(5'b01110, 8'h00, 8'h00, 8'h02, 8'h31, 1, 8'h31, 3'd0, 4'b0100);
    vt[24] = v(5'b00110, 8'h00, 8'h77, 8'h02, 8'h31, 0, 8'h31, 3'd1, 4'b0000);
    vt[25] = v(5'b00010, 8'h00, 8'h00, 8'h77, 8'h31, 0, 8'h31, 3'd0, 4'b0100);

    idle_inputs();
    rst = 1'b1;
    tick();
    chk("reset_values", outs(), RST_OUTS);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 26; i++) begin
      {call, ret, push, pop, clr_err} = vt[i].ops;
      pc_in   = vt[i].pc;
      data_in = vt[i].din;
      tick();
      chk($sformatf("vec%0d", i), outs(),
          {vt[i].e_dout, vt[i].e_rpc, vt[i].e_pl, vt[i].e_lnk, vt[i].e_lvl, vt[i].e_st,
           1'b0, 1'b0, 4'h0});
    end
    idle_inputs();

`ifdef CTRL_STACK_INT_EN
    // Interrupt entry then reti.
    do_reset();
    pc_in = 8'h40; flags_in = 4'b1010; eint = 1;
    tick();
    chk("int_detect", {busy, level, pc_load}, {1'b0, 3'd0, 1'b0});
    tick();
    chk("int_accept", {busy, level, pc_load}, {1'b1, 3'd2 - 3'd1, 1'b0});
    tick();
    chk("int_vector", {busy, level, pc_load, ret_pc}, {1'b1, 3'd2, 1'b1, 8'h10});
    eint = 0;
    tick();
    chk("int_done", {busy, pc_load, level}, {1'b0, 1'b0, 3'd2});
    reti = 1;
    tick();
    reti = 0;
    chk("reti_flags", {flags_load, flags_out, level, busy, pc_load}, {1'b1, 4'b1010, 3'd1, 1'b1, 1'b0});
    tick();
    chk("reti_pc", {flags_load, pc_load, ret_pc, level}, {1'b0, 1'b1, 8'h40, 3'd0});
    tick();
    chk("reti_done", {busy, pc_load, empty}, {1'b0, 1'b0, 1'b1});

    // eint rise coinciding with push; second eint during the ISR.
    do_reset();
    pc_in = 8'h60; data_in = 8'h55; flags_in = 4'b0011; push = 1; eint = 1;
    tick();
    push = 0;
    chk("push_wins", {level, busy}, {3'd1, 1'b0});
    pc_in = 8'h61;
    tick();
    chk("late_accept", {level, busy}, {3'd2, 1'b1});
    tick();
    chk("late_vector", {level, pc_load, ret_pc}, {3'd3, 1'b1, 8'h10});
    eint = 0;
    tick();
    eint = 1;
    tick();
    tick();
    tick();
    chk("isr_blocks", {level, busy}, {3'd3, 1'b0});
    eint = 0; reti = 1;
    tick();
    reti = 0;
    chk("reti2_flags", {flags_load, flags_out, level}, {1'b1, 4'b0011, 3'd2});
    pc_in = 8'h80;
    tick();
    chk("reti2_pc", {pc_load, ret_pc, level, busy}, {1'b1, 8'h61, 3'd1, 1'b1});
    tick();
    chk("reti2_tail", {busy, level}, {1'b0, 3'd1});
    tick();
    chk("pend_accept", {busy, level}, {1'b1, 3'd2});
    tick();
    chk("pend_vector", {pc_load, ret_pc, level}, {1'b1, 8'h10, 3'd3});

    // Reset while in INT_SV.
    do_reset();
    pc_in = 8'h40; data_in = 8'h00; eint = 1;
    tick();
    tick();
    chk("in_int_sv", {busy, level}, {1'b1, 3'd1});
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_int", outs(), RST_OUTS);
    tick();
    rst = 1'b0; eint = 0;
    tick();
    tick();
    chk("rst_no_resume", {busy, level, pc_load}, {1'b0, 3'd0, 1'b0});
`else
    // Interrupt feature absent: eint, reti, flags_in have no effect.
    do_reset();
    pc_in = 8'h40; flags_in = 4'b1010; eint = 1;
    tick();
    tick();
    tick();
    chk("eint_inert", {busy, level, pc_load, flags_out}, {1'b0, 3'd0, 1'b0, 4'h0});
    eint = 0; reti = 1; push = 1; data_in = 8'h5A;
    tick();
    push = 0;
    chk("reti_ignored_push", {level, flags_load, busy}, {3'd1, 1'b0, 1'b0});
    tick();
    reti = 0;
    chk("reti_inert", {level, unf, flags_load, pc_load}, {3'd1, 1'b0, 1'b0, 1'b0});
    push = 1;
    tick();
    push = 0;
    chk("push_before_rst", {level}, {3'd2});
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_op", outs(), RST_OUTS);
    tick();
    rst = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
